cache_cmd_dispatch: RTL and testbench
=====================================

CACHE_CMD_DISPATCH -- requirements
Module: cache_cmd_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, trace command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ADDRESS_BITS, default 32, trace address width.
REQ-003 SHALL have parameter OFFSET_BITS, default 6, line offset width (64-byte lines).
REQ-004 SHALL have parameter INDEX_BITS, default 14, set index width (16K sets); TAG_BITS = ADDRESS_BITS-INDEX_BITS-OFFSET_BITS (12).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port in_valid  in  1  trace command present.
REQ-008 SHALL have port in_ready  out  1  FIFO can accept this cycle.
REQ-009 SHALL have port in_cmd  in  4  trace command: 0 READ, 1 WRITE, 2 I_FETCH, 3 L2_INVAL, 4 L2_DATA_RQ, 8 CLR, 9 PRINT.
REQ-010 SHALL have port in_addr  in  ADDRESS_BITS  trace address.
REQ-011 SHALL have port d_req_valid / d_req_ready  out / in  1 / 1  data-cache request handshake.
REQ-012 SHALL have port d_req_op  out  3  data-cache op: in_cmd value 0, 1, 3 or 4.
REQ-013 SHALL have port i_req_valid / i_req_ready  out / in  1 / 1  instruction-cache request handshake.
REQ-014 SHALL have port req_tag / req_index / req_offset  out  TAG_BITS / INDEX_BITS / OFFSET_BITS  address fields shared by both request ports.
REQ-015 SHALL have port clr_pulse, print_pulse  out  1 each  one-cycle strobes.
REQ-016 SHALL have port busy  out  1  FIFO non-empty or request pending.
REQ-017 SHALL have port read_count, write_count, fetch_count  out  32 each  dispatched-op statistics.
REQ-018 SHALL have port bad_cmd_count  out  16  dropped illegal commands.

Function
REQ-019 SHALL push {in_cmd,in_addr} when in_valid && in_ready; in_ready = (occupancy < FIFO_DEPTH), not relieved by a same-cycle pop.
REQ-020 SHALL run FSM IDLE -> {REQ_D, REQ_I, STROBE} -> IDLE, popping the FIFO head on the IDLE->next transition; strictly in order, one command in flight.
REQ-021 SHALL route cmd 0/1/3/4 to REQ_D, cmd 2 to REQ_I, cmd 8/9 to STROBE; any other cmd is popped and dropped in IDLE, bad_cmd_count +1 (saturating at 0xFFFF), no output activity.
REQ-022 SHALL register req_tag = addr[31:20], req_index = addr[19:6], req_offset = addr[5:0] and d_req_op on entry to REQ_D/REQ_I; fields and valid held stable until ready.
REQ-023 SHALL assert d_req_valid (REQ_D) or i_req_valid (REQ_I) exactly while in that state; never both; return to IDLE on the cycle valid && ready.
REQ-024 SHALL give latency: command pushed at edge N into empty FIFO -> request valid after edge N+2; with ready held high, one command dispatched every 2 cycles.
REQ-025 SHALL in STROBE assert clr_pulse (cmd 8) or print_pulse (cmd 9) for exactly one cycle, then IDLE.
REQ-026 SHALL increment read/write/fetch_count on the d/i handshake of cmd 0/1/2 respectively, wrapping at 2^32; L2_INVAL/L2_DATA_RQ not counted.
REQ-027 SHALL clear read/write/fetch_count in the clr_pulse cycle; bad_cmd_count not cleared by CLR.
REQ-028 SHALL hold outputs and FIFO unchanged while a request is stalled (ready low) indefinitely; pushes continue until full.

Reset
REQ-029 SHALL on rst asynchronously empty the FIFO, enter IDLE, and drive in_ready=1 once rst deasserts, all valids/strobes/busy=0, req fields=0, all counters=0.
REQ-030 SHALL discard any in-flight request when rst asserts mid-handshake; no handshake completes during reset.

Configuration
REQ-031 SHALL, with CMD_STATS_EN defined, implement the counters of REQ-017/018; without it, those outputs SHALL be constant 0 and no counter flops synthesized, dispatch behaviour unchanged.

Verification
REQ-032 SHALL cover: push cmd 0, addr 0x1234_5678, d_req_ready=1 -> d_req_valid two cycles later, op 0, tag 0x123, index 0x1159, offset 0x38; read_count=1.
REQ-033 SHALL cover: push 2 @0x0000_0040 with i_req_ready=0 for 5 cycles -> i_req_valid held, index 0x0001; no pop; fetch_count increments only on release.
REQ-034 SHALL cover: 5 pushes with d_req_ready=0 -> in_ready=0 after 4th; 5th held until first handshake.
REQ-035 SHALL cover: cmds 1,1,8,0 -> write_count 2 then 0 at clr_pulse, read_count=1 after; cmd 6 -> bad_cmd_count=1, no request.
REQ-036 SHALL cover: rst asserted while d_req_valid=1 -> d_req_valid=0 asynchronously, busy=0, counters 0.

Source files
------------

// File: rtl/cache_cmd_dispatch.sv
// cache_cmd_dispatch: queues trace commands in a small FIFO and dispatches them
// in order, one at a time, to the data-cache port, the instruction-cache port,
// or the clear/print strobes.
// Optional feature macro: CMD_STATS_EN (dispatched-op and dropped-command counters).
module cache_cmd_dispatch #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned OFFSET_BITS  = 6,
    parameter int unsigned INDEX_BITS   = 14,
    localparam int unsigned TAG_BITS    = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_cmd,
    input  logic [ADDRESS_BITS-1:0] in_addr,
    output logic                    d_req_valid,
    input  logic                    d_req_ready,
    output logic [2:0]              d_req_op,
    output logic                    i_req_valid,
    input  logic                    i_req_ready,
    output logic [TAG_BITS-1:0]     req_tag,
    output logic [INDEX_BITS-1:0]   req_index,
    output logic [OFFSET_BITS-1:0]  req_offset,
    output logic                    clr_pulse,
    output logic                    print_pulse,
    output logic                    busy,
    output logic [31:0]             read_count,
    output logic [31:0]             write_count,
    output logic [31:0]             fetch_count,
    output logic [15:0]             bad_cmd_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]              cmd;
        logic [ADDRESS_BITS-1:0] addr;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ_D,
        ST_REQ_I,
        ST_STROBE
    } state_t;

    fifo_entry_t            r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_avail;
    logic                   r_in_ready;
    state_t                 r_state;
    logic                   r_d_valid;
    logic                   r_i_valid;
    logic                   r_clr;
    logic                   r_print;
    logic                   r_busy;
    logic [2:0]             r_op;
    logic [TAG_BITS-1:0]    r_tag;
    logic [INDEX_BITS-1:0]  r_index;
    logic [OFFSET_BITS-1:0] r_offset;

    state_t                 w_state_next;
    fifo_entry_t            w_head;
    logic                   w_push;
    logic                   w_pop;
    logic [CNT_W-1:0]       w_count_next;
    logic                   w_load;
    logic                   w_clr_set;
    logic                   w_print_set;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_push       = in_valid && r_in_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_load       = w_pop && ((w_state_next == ST_REQ_D) || (w_state_next == ST_REQ_I));
    assign w_clr_set    = w_pop && (w_state_next == ST_STROBE) && !w_head.cmd[0];
    assign w_print_set  = w_pop && (w_state_next == ST_STROBE) && w_head.cmd[0];

    // FIFO storage write; contents need no reset, pointers and count do
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo_entry_t'({in_cmd, in_addr});
        end
    end

    // FIFO pointers, occupancy, and a one-cycle-delayed "head available" flag
    // that gives the two-edge push-to-request latency; it drops for a cycle
    // after every pop so a stale count is never acted on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_avail    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_avail    <= (r_count != '0) && !w_pop;
            r_in_ready <= (w_count_next < CNT_W'(FIFO_DEPTH));
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // FSM next state and pop decision; illegal commands are popped and stay in IDLE
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_avail) begin
                    w_pop = 1'b1;
                    case (w_head.cmd)
                        4'd0, 4'd1, 4'd3, 4'd4: w_state_next = ST_REQ_D;
                        4'd2:                   w_state_next = ST_REQ_I;
                        4'd8, 4'd9:             w_state_next = ST_STROBE;
                        default:                w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_REQ_D:  if (d_req_ready) w_state_next = ST_IDLE;
            ST_REQ_I:  if (i_req_ready) w_state_next = ST_IDLE;
            ST_STROBE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Registered request/strobe outputs, decoded from the next state; fields load on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_valid <= 1'b0;
            r_i_valid <= 1'b0;
            r_clr     <= 1'b0;
            r_print   <= 1'b0;
            r_busy    <= 1'b0;
            r_op      <= '0;
            r_tag     <= '0;
            r_index   <= '0;
            r_offset  <= '0;
        end else begin
            r_d_valid <= (w_state_next == ST_REQ_D);
            r_i_valid <= (w_state_next == ST_REQ_I);
            r_clr     <= w_clr_set;
            r_print   <= w_print_set;
            r_busy    <= (w_count_next != '0) || (w_state_next != ST_IDLE);
            if (w_load) begin
                r_op     <= w_head.cmd[2:0];
                r_tag    <= w_head.addr[ADDRESS_BITS-1 -: TAG_BITS];
                r_index  <= w_head.addr[OFFSET_BITS +: INDEX_BITS];
                r_offset <= w_head.addr[OFFSET_BITS-1:0];
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign d_req_valid = r_d_valid;
    assign i_req_valid = r_i_valid;
    assign d_req_op    = r_op;
    assign req_tag     = r_tag;
    assign req_index   = r_index;
    assign req_offset  = r_offset;
    assign clr_pulse   = r_clr;
    assign print_pulse = r_print;
    assign busy        = r_busy;

`ifdef CMD_STATS_EN
    logic [31:0] r_read_count;
    logic [31:0] r_write_count;
    logic [31:0] r_fetch_count;
    logic [15:0] r_bad_count;
    logic        w_d_hs;
    logic        w_i_hs;
    logic        w_drop;

    assign w_d_hs = r_d_valid && d_req_ready;
    assign w_i_hs = r_i_valid && i_req_ready;
    assign w_drop = w_pop && (w_state_next == ST_IDLE);

    // Op statistics; the op counters clear as clr_pulse rises, the drop counter saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_count  <= '0;
            r_write_count <= '0;
            r_fetch_count <= '0;
            r_bad_count   <= '0;
        end else begin
            if (w_clr_set) begin
                r_read_count  <= '0;
                r_write_count <= '0;
                r_fetch_count <= '0;
            end else begin
                if (w_d_hs && (r_op == 3'd0)) r_read_count  <= r_read_count + 32'd1;
                if (w_d_hs && (r_op == 3'd1)) r_write_count <= r_write_count + 32'd1;
                if (w_i_hs)                   r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_drop && (r_bad_count != 16'hFFFF)) r_bad_count <= r_bad_count + 16'd1;
        end
    end

    assign read_count    = r_read_count;
    assign write_count   = r_write_count;
    assign fetch_count   = r_fetch_count;
    assign bad_cmd_count = r_bad_count;
`else
    assign read_count    = 32'd0;
    assign write_count   = 32'd0;
    assign fetch_count   = 32'd0;
    assign bad_cmd_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_cmd_dispatch.sv
// Directed self-checking bench for cache_cmd_dispatch (works with or without CMD_STATS_EN).
module tb_cache_cmd_dispatch;

`ifdef CMD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_addr;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [2:0]  d_req_op;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [11:0] req_tag;
    logic [13:0] req_index;
    logic [5:0]  req_offset;
    logic        clr_pulse;
    logic        print_pulse;
    logic        busy;
    logic [31:0] read_count;
    logic [31:0] write_count;
    logic [31:0] fetch_count;
    logic [15:0] bad_cmd_count;

    int n_checks = 0;
    int n_errors = 0;

    int mon_dv, mon_iv, mon_clr, mon_pr;
    logic [31:0] wc_before;
    logic [2:0]  exp_ops [3];
    int waited;

    cache_cmd_dispatch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_op(d_req_op),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .req_tag(req_tag), .req_index(req_index), .req_offset(req_offset),
        .clr_pulse(clr_pulse), .print_pulse(print_pulse), .busy(busy),
        .read_count(read_count), .write_count(write_count), .fetch_count(fetch_count),
        .bad_cmd_count(bad_cmd_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected counter value: real count when statistics are built in, else zero
    function automatic logic [31:0] st(input int unsigned n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    // Present one command at a negedge, hold it until accepted, return at the negedge after acceptance
    task automatic push(input logic [3:0] c, input logic [31:0] a, output int w);
        in_cmd   = c;
        in_addr  = a;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check_eq("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the block to go idle, bounded
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) check_eq(tag, 32'd1, 32'd0);
    endtask

    // Observe outputs for a number of cycles, tallying activity
    task automatic monitor(input int cycles);
        mon_dv = 0; mon_iv = 0; mon_clr = 0; mon_pr = 0;
        wc_before = write_count;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (d_req_valid) begin
                if (mon_dv < 3) check_eq("mon_op", 32'(d_req_op), 32'(exp_ops[mon_dv]));
                mon_dv++;
            end
            if (i_req_valid) mon_iv++;
            if (print_pulse) mon_pr++;
            if (clr_pulse) begin
                mon_clr++;
                check_eq("clr_wc_before", wc_before, st(2));
                check_eq("clr_wc_zero", write_count, 32'd0);
                check_eq("clr_rc_zero", read_count, 32'd0);
                check_eq("clr_fc_zero", fetch_count, 32'd0);
            end
            wc_before = write_count;
        end
    endtask

    initial begin
        exp_ops[0] = 3'd1; exp_ops[1] = 3'd1; exp_ops[2] = 3'd0;
        rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0;
        d_req_ready = 1'b1; i_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_d_valid", 32'(d_req_valid), 32'd0);
        check_eq("rst_i_valid", 32'(i_req_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_tag", 32'(req_tag), 32'd0);
        check_eq("rst_rc", read_count, 32'd0);

        // READ 0x1234_5678: valid after the second edge past the push
        push(4'd0, 32'h1234_5678, waited);
        check_eq("t1_lat_a", 32'(d_req_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_lat_b", 32'(d_req_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_valid", 32'(d_req_valid), 32'd1);
        check_eq("t1_i_valid", 32'(i_req_valid), 32'd0);
        check_eq("t1_op", 32'(d_req_op), 32'd0);
        check_eq("t1_tag", 32'(req_tag), 32'h123);
        check_eq("t1_index", 32'(req_index), 32'h1159);
        check_eq("t1_offset", 32'(req_offset), 32'h38);
        @(negedge clk);
        check_eq("t1_done", 32'(d_req_valid), 32'd0);
        check_eq("t1_rc", read_count, st(1));
        check_eq("t1_busy", 32'(busy), 32'd0);

        // I_FETCH 0x40 stalled for 5 cycles
        i_req_ready = 1'b0;
        push(4'd2, 32'h0000_0040, waited);
        repeat (2) @(negedge clk);
        check_eq("t2_valid", 32'(i_req_valid), 32'd1);
        check_eq("t2_d_valid", 32'(d_req_valid), 32'd0);
        check_eq("t2_index", 32'(req_index), 32'h1);
        check_eq("t2_tag", 32'(req_tag), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t2_hold_valid", 32'(i_req_valid), 32'd1);
            check_eq("t2_hold_index", 32'(req_index), 32'h1);
            check_eq("t2_hold_fc", fetch_count, 32'd0);
        end
        check_eq("t2_busy", 32'(busy), 32'd1);
        i_req_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_release", 32'(i_req_valid), 32'd0);
        check_eq("t2_fc", fetch_count, st(1));
        wait_idle("t2_idle_timeout");

        // WRITE, WRITE, CLR, READ with ready high
        fork
            begin
                push(4'd1, 32'h0000_2000, waited);
                push(4'd1, 32'h0000_2040, waited);
                push(4'd8, 32'h0000_0000, waited);
                push(4'd0, 32'h0000_3000, waited);
            end
            monitor(20);
        join
        check_eq("t4_d_cycles", 32'(mon_dv), 32'd3);
        check_eq("t4_i_cycles", 32'(mon_iv), 32'd0);
        check_eq("t4_clr_cycles", 32'(mon_clr), 32'd1);
        check_eq("t4_print_cycles", 32'(mon_pr), 32'd0);
        check_eq("t4_wc", write_count, st(0));
        check_eq("t4_rc", read_count, st(1));
        check_eq("t4_fc", fetch_count, st(0));
        wait_idle("t4_idle_timeout");

        // Illegal command 6 is dropped silently
        push(4'd6, 32'h0000_ABC0, waited);
        monitor(8);
        check_eq("t5_bad_act", 32'(mon_dv + mon_iv + mon_clr + mon_pr), 32'd0);
        check_eq("t5_bad_count", 32'(bad_cmd_count), st(1));
        check_eq("t5_busy", 32'(busy), 32'd0);

        // PRINT strobe is one cycle and does not touch counters
        push(4'd9, 32'h0000_0000, waited);
        monitor(8);
        check_eq("t5_print_cycles", 32'(mon_pr), 32'd1);
        check_eq("t5_print_clr", 32'(mon_clr), 32'd0);
        check_eq("t5_print_d", 32'(mon_dv), 32'd0);
        check_eq("t5_print_rc", read_count, st(1));

        // Fill the FIFO behind a stalled READ
        d_req_ready = 1'b0;
        push(4'd0, 32'h0000_0100, waited);
        repeat (2) @(negedge clk);
        check_eq("t3_stall_valid", 32'(d_req_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            push(4'd1, 32'(32'h1000 * (k + 1)), waited);
            check_eq("t3_push_wait", 32'(waited), 32'd0);
        end
        check_eq("t3_full", 32'(in_ready), 32'd0);
        in_cmd = 4'd1; in_addr = 32'h0000_5000; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t3_hold_ready", 32'(in_ready), 32'd0);
            check_eq("t3_hold_valid", 32'(d_req_valid), 32'd1);
            check_eq("t3_hold_index", 32'(req_index), 32'h4);
            check_eq("t3_hold_op", 32'(d_req_op), 32'd0);
        end
        d_req_ready = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("t3_fifth_wait", 32'(waited), 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle("t3_idle_timeout");
        check_eq("t3_rc", read_count, st(2));
        check_eq("t3_wc", write_count, st(5));

        // Reset in the middle of a stalled handshake
        d_req_ready = 1'b0;
        push(4'd0, 32'h0077_7000, waited);
        push(4'd1, 32'h0000_8000, waited);
        waited = 0;
        while (!d_req_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("t6_pre_valid", 32'(d_req_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async_valid", 32'(d_req_valid), 32'd0);
        check_eq("t6_async_busy", 32'(busy), 32'd0);
        check_eq("t6_async_rc", read_count, 32'd0);
        check_eq("t6_async_wc", write_count, 32'd0);
        check_eq("t6_async_bad", 32'(bad_cmd_count), 32'd0);
        check_eq("t6_async_tag", 32'(req_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d_req_ready = 1'b1;
        check_eq("t6_in_ready", 32'(in_ready), 32'd1);
        monitor(6);
        check_eq("t6_no_dispatch", 32'(mon_dv + mon_iv), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
